// File: rtl/clk_div_bank_if.sv
// rtl/clk_div_bank_if.sv - config/restart port and divided outputs of clk_div_bank
interface clk_div_bank_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int CH_W   = 4
);
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              sync_restart;
    logic              cfg_ack;
    logic [NUM_CH-1:0] tick_out;
    logic [NUM_CH-1:0] clk_out;

    modport master (
        output cfg_we, cfg_ch, cfg_div, sync_restart,
        input  cfg_ack, tick_out, clk_out
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_div, sync_restart,
        output cfg_ack, tick_out, clk_out
    );
endinterface

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of runtime-programmable integer clock dividers
module clk_div_bank #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 1,
    parameter int CH_W    = 4
) (
    input  logic           clk_in,
    input  logic           rst_in,
    clk_div_bank_if.slave  bus
);
    logic [CNT_W-1:0]  cnt     [NUM_CH];
    logic [CNT_W-1:0]  act_div [NUM_CH];
    logic [CNT_W-1:0]  shd_div [NUM_CH];
    logic [CNT_W-1:0]  shd_nxt [NUM_CH];
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] clk_q;
    logic              ack_q;

    // Shadow value including a write landing this cycle; only a restart consumes it
    // immediately, the terminal-edge apply uses the value held before this edge.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            shd_nxt[i] = shd_div[i];
            if (bus.cfg_we && (bus.cfg_ch == CH_W'(i)))
                shd_nxt[i] = bus.cfg_div;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ack_q  <= 1'b0;
            tick_q <= '0;
            clk_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]     <= '0;
                act_div[i] <= CNT_W'(DEF_DIV);
                shd_div[i] <= CNT_W'(DEF_DIV);
            end
        end else begin
            ack_q <= bus.cfg_we && (32'(bus.cfg_ch) < NUM_CH);
            for (int i = 0; i < NUM_CH; i++) begin
                shd_div[i] <= shd_nxt[i];
                if (bus.sync_restart) begin
                    cnt[i]     <= '0;
                    tick_q[i]  <= 1'b0;
                    clk_q[i]   <= 1'b0;
                    act_div[i] <= shd_nxt[i];
                end else if (act_div[i] == '0) begin
                    cnt[i]     <= '0;
                    tick_q[i]  <= 1'b0;
                    clk_q[i]   <= 1'b0;
                    act_div[i] <= shd_div[i];
                end else if (cnt[i] == act_div[i] - CNT_W'(1)) begin
                    cnt[i]     <= '0;
                    act_div[i] <= shd_div[i];
                    // A channel being disabled parks low instead of finishing its toggle.
                    if (shd_div[i] == '0) begin
                        tick_q[i] <= 1'b0;
                        clk_q[i]  <= 1'b0;
                    end else begin
                        tick_q[i] <= 1'b1;
                        clk_q[i]  <= ~clk_q[i];
                    end
                end else begin
                    cnt[i]    <= cnt[i] + CNT_W'(1);
                    tick_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.cfg_ack  = ack_q;
    assign bus.tick_out = tick_q;
    assign bus.clk_out  = clk_q;
endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - randomized bench for clk_div_bank against a period-level model
module tb_clk_div_bank;
    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 16;
    localparam int DEF_DIV = 1;
    localparam int CH_W    = 4;

    logic clk_in = 1'b0;
    logic rst_in;
    int   vectors = 0;
    int   errors  = 0;

    clk_div_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

    clk_div_bank #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV), .CH_W(CH_W)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus(bus.slave)
    );

    always #5 clk_in = ~clk_in;

    // Model: each channel is a running period of length per, el edges into it.
    int el   [NUM_CH];
    int per  [NUM_CH];
    int pend [NUM_CH];
    bit ph   [NUM_CH];
    bit mt   [NUM_CH];
    bit mack;

    task automatic model_step(input bit rst, input bit we, input int ch, input int dv, input bit rs);
        if (rst) begin
            mack = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                el[i] = 0; per[i] = DEF_DIV; pend[i] = DEF_DIV; ph[i] = 1'b0; mt[i] = 1'b0;
            end
        end else begin
            mack = we && (ch < NUM_CH);
            for (int i = 0; i < NUM_CH; i++) begin
                bit wr;
                wr = we && (ch == i);
                mt[i] = 1'b0;
                if (rs) begin
                    if (wr) pend[i] = dv;
                    per[i] = pend[i]; el[i] = 0; ph[i] = 1'b0;
                end else begin
                    el[i]++;
                    if (per[i] == 0) begin
                        per[i] = pend[i]; el[i] = 0; ph[i] = 1'b0;
                    end else if (el[i] == per[i]) begin
                        el[i] = 0;
                        per[i] = pend[i];
                        if (per[i] == 0) ph[i] = 1'b0;
                        else begin
                            mt[i] = 1'b1; ph[i] = ~ph[i];
                        end
                    end
                    if (wr) pend[i] = dv;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [NUM_CH-1:0] et, ec;
        for (int i = 0; i < NUM_CH; i++) begin
            et[i] = mt[i]; ec[i] = ph[i];
        end
        vectors += 3;
        if (bus.tick_out !== et) begin
            errors++;
            $display("FAIL tick_out t=%0t got %b exp %b", $time, bus.tick_out, et);
        end
        if (bus.clk_out !== ec) begin
            errors++;
            $display("FAIL clk_out t=%0t got %b exp %b", $time, bus.clk_out, ec);
        end
        if (bus.cfg_ack !== mack) begin
            errors++;
            $display("FAIL cfg_ack t=%0t got %b exp %b", $time, bus.cfg_ack, mack);
        end
    endtask

    task automatic chk_lit(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Drive one cycle, let the edge happen, then advance the model and compare.
    task automatic cycle(input bit rst, input bit we, input int ch, input int dv, input bit rs);
        rst_in           = rst;
        bus.cfg_we       = we;
        bus.cfg_ch       = CH_W'(ch);
        bus.cfg_div      = CNT_W'(dv);
        bus.sync_restart = rs;
        @(posedge clk_in);
        #1;
        model_step(rst, we, ch, dv, rs);
        check_model();
    endtask

    initial begin
        logic [9:0] tv, cv;
        logic [3:0] t3;
        rst_in = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0; bus.sync_restart = 1'b0;

        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk_lit("reset_tick", 16'(bus.tick_out), 16'h0);
        chk_lit("reset_clk",  16'(bus.clk_out),  16'h0);
        chk_lit("reset_ack",  16'(bus.cfg_ack),  16'h0);

        cycle(0, 0, 0, 0, 0);
        chk_lit("div1_tick_a", 16'(bus.tick_out), 16'hF);
        chk_lit("div1_clk_a",  16'(bus.clk_out),  16'hF);
        cycle(0, 0, 0, 0, 0);
        chk_lit("div1_tick_b", 16'(bus.tick_out), 16'hF);
        chk_lit("div1_clk_b",  16'(bus.clk_out),  16'h0);

        cycle(0, 1, 1, 5, 1);
        chk_lit("ack_after_write", 16'(bus.cfg_ack), 16'h1);
        chk_lit("restart_clk",     16'(bus.clk_out), 16'h0);
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, 0, 0, 0);
            tv[k] = bus.tick_out[1];
            cv[k] = bus.clk_out[1];
        end
        chk_lit("div5_ticks", 16'(tv), 16'h210);
        chk_lit("div5_clk",   16'(cv), 16'h1F0);

        cycle(0, 1, NUM_CH, 9, 0);
        chk_lit("bad_ch_no_ack", 16'(bus.cfg_ack), 16'h0);

        cycle(0, 1, 3, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk_lit("ch3_off_tick", 16'(bus.tick_out[3]), 16'h0);
        chk_lit("ch3_off_clk",  16'(bus.clk_out[3]),  16'h0);
        cycle(0, 1, 3, 3, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0, 0);
            t3[k] = bus.tick_out[3];
        end
        chk_lit("ch3_div3_first", 16'(t3), 16'h8);

        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk_lit("midrst_tick", 16'(bus.tick_out), 16'h0);
        chk_lit("midrst_clk",  16'(bus.clk_out),  16'h0);

        for (int n = 0; n < 3000; n++) begin
            bit r, w, s;
            r = ($urandom_range(0, 499) == 0);
            w = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 79) == 0);
            cycle(r, w, int'($urandom_range(0, 5)), int'($urandom_range(0, 9)), s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
